pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the execute stage. Takes the branch/jump redirect and hold requests, and drives the PC redirect plus the flush and stall controls for pc_reg, if_id and id_ex.

---
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Execute-stage pipeline sequencer: redirect/flush/stall control for pc_reg, if_id and id_ex,
// with single-entry redirect buffering across bus holds and debug statistics.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_ena_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  output logic        jump_ena_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        hold_timeout_o,
  output logic [31:0] jump_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam state_t      AFTER_ISSUE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam bit          TO_EN    = (HOLD_TIMEOUT != 0);
  localparam logic [15:0] TO_MATCH = 16'((HOLD_TIMEOUT == 0) ? 0 : HOLD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        pend, pend_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic [3:0]  flush_cnt, flush_cnt_nxt;
  logic [15:0] hold_cnt;
  logic        hold_any;
  logic        issue;
  logic [31:0] issue_addr;
  logic        flush_c;
  logic        stall_c;

  assign hold_any = hold_ex_i | hold_bus_i;

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    flush_cnt_nxt = flush_cnt;
    issue         = 1'b0;
    issue_addr    = '0;
    flush_c       = 1'b0;
    stall_c       = hold_any;
    case (state)
      RUN: begin
        if (jump_ena_i && !hold_bus_i) begin
          issue         = 1'b1;
          issue_addr    = jump_addr_i;
          flush_c       = 1'b1;
          flush_cnt_nxt = FLUSH_INIT;
          state_nxt     = AFTER_ISSUE;
        end else if (jump_ena_i) begin
          pend_nxt      = 1'b1;
          pend_addr_nxt = jump_addr_i;
          state_nxt     = HOLD;
        end else if (hold_any) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!hold_any) begin
          if (pend) begin
            issue         = 1'b1;
            issue_addr    = pend_addr;
            flush_c       = 1'b1;
            pend_nxt      = 1'b0;
            flush_cnt_nxt = FLUSH_INIT;
            state_nxt     = AFTER_ISSUE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        stall_c = hold_any & ~flush_c;
        // flush_cnt is the number of FLUSH-state cycles still owed, including this one
        if (!hold_any) begin
          if (flush_cnt <= 4'd1) begin
            flush_cnt_nxt = '0;
            state_nxt     = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Gating with rst_n keeps the combinational controls quiet while reset is held
  assign jump_ena_o  = issue & rst_n;
  assign jump_addr_o = (issue & rst_n) ? issue_addr : '0;
  assign flush_o     = flush_c & rst_n;
  assign stall_o     = stall_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pend      <= 1'b0;
      pend_addr <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      pend_addr <= pend_addr_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt       <= '0;
      hold_timeout_o <= 1'b0;
    end else begin
      if (hold_any) begin
        if (hold_cnt != '1) begin
          hold_cnt <= hold_cnt + 16'd1;
        end
        if (TO_EN && (hold_cnt == TO_MATCH)) begin
          hold_timeout_o <= 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (jump_ena_o) begin
        jump_cnt_o <= jump_cnt_o + 32'd1;
      end
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_ena_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        jump_ena_o;
  logic [31:0] jump_addr_o;
  logic        flush_o;
  logic        stall_o;
  logic        hold_timeout_o;
  logic [31:0] jump_cnt_o;
  logic [31:0] stall_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipe_ctrl #(
    .FLUSH_CYCLES(2),
    .HOLD_TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_ena_i    (jump_ena_i),
    .jump_addr_i   (jump_addr_i),
    .hold_ex_i     (hold_ex_i),
    .hold_bus_i    (hold_bus_i),
    .jump_ena_o    (jump_ena_o),
    .jump_addr_o   (jump_addr_o),
    .flush_o       (flush_o),
    .stall_o       (stall_o),
    .hold_timeout_o(hold_timeout_o),
    .jump_cnt_o    (jump_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic je, input logic [31:0] ja, input logic hx, input logic hb);
    @(negedge clk);
    jump_ena_i  = je;
    jump_addr_i = ja;
    hold_ex_i   = hx;
    hold_bus_i  = hb;
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    jump_ena_i  = 1'b0;
    jump_addr_i = '0;
    hold_ex_i   = 1'b0;
    hold_bus_i  = 1'b0;
    rst_n       = 1'b1;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    jump_ena_i  = 1'b0;
    jump_addr_i = '0;
    hold_ex_i   = 1'b0;
    hold_bus_i  = 1'b0;

    // 1: reset, then a mid-cycle reset while stalling
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_jump_ena", jump_ena_o, 0);
    chk("rst_jump_addr", jump_addr_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_timeout", hold_timeout_o, 0);
    chk("rst_jump_cnt", jump_cnt_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_rst_stall", stall_o, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", stall_o, 0);
    chk("async_rst_stall_cnt", stall_cnt_o, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", stall_o, 0);
    chk("post_rst_flush", flush_o, 0);

    // 2: taken branch with no hold
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    chk("beq_jump_ena", jump_ena_o, 1);
    chk("beq_jump_addr", jump_addr_o, 32'h40);
    chk("beq_flush1", flush_o, 1);
    chk("beq_stall", stall_o, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("beq_pulse", jump_ena_o, 0);
    chk("beq_addr_zero", jump_addr_o, 0);
    chk("beq_flush2", flush_o, 1);
    chk("beq_jump_cnt", jump_cnt_o, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("beq_flush_end", flush_o, 0);

    // 3: redirect arriving under a 5-cycle bus wait
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_0080, 1'b0, 1'b1);
      chk($sformatf("busw_stall%0d", i), stall_o, 1);
      chk($sformatf("busw_nojump%0d", i), jump_ena_o, 0);
      chk($sformatf("busw_noflush%0d", i), flush_o, 0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("busw_replay", jump_ena_o, 1);
    chk("busw_replay_addr", jump_addr_o, 32'h80);
    chk("busw_replay_flush", flush_o, 1);
    chk("busw_replay_stall", stall_o, 0);
    chk("busw_stall_cnt", stall_cnt_o, 5);
    chk("busw_timeout", hold_timeout_o, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("busw_flush2", flush_o, 1);
    chk("busw_pulse", jump_ena_o, 0);
    chk("busw_jump_cnt", jump_cnt_o, 2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("busw_flush_end", flush_o, 0);

    // 4: ex hold lands inside the flush window
    do_reset();
    chk("r4_timeout_clr", hold_timeout_o, 0);
    drive(1'b1, 32'h0000_00C0, 1'b0, 1'b0);
    chk("hf_jump", jump_ena_o, 1);
    chk("hf_flush_c1", flush_o, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("hf_flush_hold%0d", i), flush_o, 1);
      chk($sformatf("hf_stall_masked%0d", i), stall_o, 0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("hf_flush_last", flush_o, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("hf_flush_end", flush_o, 0);
    chk("hf_stall_cnt", stall_cnt_o, 0);
    chk("hf_timeout", hold_timeout_o, 0);
    chk("hf_jump_cnt", jump_cnt_o, 1);

    // 5: hold timeout after exactly 4 hold cycles, sticky after release
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("to_pre%0d", i), hold_timeout_o, 0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("to_set", hold_timeout_o, 1);
    chk("to_stall_rel", stall_o, 0);
    chk("to_stall_cnt", stall_cnt_o, 4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("to_sticky", hold_timeout_o, 1);

    // 6: reset while a redirect is pending in HOLD
    do_reset();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    chk("pr_nojump", jump_ena_o, 0);
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    chk("pr_stall", stall_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("pr_rst_stall", stall_o, 0);
    chk("pr_rst_jump", jump_ena_o, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("pr_rel_jump", jump_ena_o, 0);
    chk("pr_rel_flush", flush_o, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pr_rel_jump2", jump_ena_o, 0);
    chk("pr_jump_cnt", jump_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
